// File: rtl/rvvLitePkg.sv
// Shared types for the CXU vector configuration unit: the vtype register
// layout, the raw instruction type and the VSET* decode helper.
package rvvLitePkg;

  localparam int XLEN = 32;

  typedef logic [31:0] vcfg_instruction_t;

  typedef struct packed {
    logic             vill;
    logic [XLEN-10:0] zeros;
    logic             vma;
    logic             vta;
    logic [2:0]       vsew;
    logic [2:0]       vlmul;
  } vtype_t;

  typedef enum logic [1:0] {
    OP_NONE     = 2'd0,
    OP_VSETVLI  = 2'd1,
    OP_VSETIVLI = 2'd2,
    OP_VSETVL   = 2'd3
  } vcfg_op_e;

  // vtype written for any rejected configuration: only vill set.
  localparam vtype_t VTYPE_ILLEGAL = vtype_t'({1'b1, {(XLEN-1){1'b0}}});

  // OP-V major opcode with funct3=OPCFG; bits [31:25] select the variant.
  function automatic vcfg_op_e vcfg_decode(input vcfg_instruction_t insn);
    casez (insn)
      32'b0????????????????111?????1010111: return OP_VSETVLI;
      32'b11???????????????111?????1010111: return OP_VSETIVLI;
      32'b1000000??????????111?????1010111: return OP_VSETVL;
      default:                              return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vcfg_vlmax_calc.sv
// Combinational vtype legality check, VLMAX and resulting vl for one AVL.
module vcfg_vlmax_calc
  import rvvLitePkg::*;
#(
  parameter int VLEN = 256,
  parameter int ELEN = 32,
  localparam int VL_BITS = $clog2(VLEN) + 1
) (
  input  vtype_t              vtype_i,
  input  logic [XLEN-1:0]     avl_i,
  output logic                vill_o,
  output logic [VL_BITS-1:0]  vlmax_o,
  output logic [VL_BITS-1:0]  vl_o
);

  localparam logic [VL_BITS-1:0] VLMAX_E8_M1 = VL_BITS'(VLEN / 8);
  localparam logic [31:0]        ELEN_W      = 32'(ELEN);

  logic [31:0]        sew_w;
  logic [2:0]         frac_sh;
  logic               frac;
  logic [VL_BITS-1:0] base;
  logic               unused_policy;

  // Tail/mask policy bits do not affect legality or VLMAX.
  assign unused_policy = vtype_i.vma ^ vtype_i.vta;

  // Legality, VLMAX and the AVL clamp; the AVL compare is done at full XLEN.
  always_comb begin
    sew_w   = 32'd8 << vtype_i.vsew;
    frac    = vtype_i.vlmul[2] && (vtype_i.vlmul != 3'b100);
    // 8 - vlmul, in modulo-8 arithmetic, for vlmul 5..7.
    frac_sh = 3'd0 - vtype_i.vlmul;
    base    = VLMAX_E8_M1 >> vtype_i.vsew;
    vill_o  = vtype_i.vill
           || (|vtype_i.zeros)
           || (vtype_i.vlmul == 3'b100)
           || (sew_w > ELEN_W)
           || (frac && (sew_w > (ELEN_W >> frac_sh)));
    if (vill_o) begin
      vlmax_o = '0;
    end else if (frac) begin
      vlmax_o = base >> frac_sh;
    end else begin
      vlmax_o = base << vtype_i.vlmul[1:0];
    end
    if (avl_i >= XLEN'(vlmax_o)) begin
      vl_o = vlmax_o;
    end else begin
      vl_o = avl_i[VL_BITS-1:0];
    end
  end

endmodule

// File: rtl/vcfg_ctx_unit.sv
// Multi-context VSET* execution unit: decodes the request, computes the new
// vl/vtype for the addressed context and returns vl for rd writeback.
module vcfg_ctx_unit
  import rvvLitePkg::*;
#(
  parameter int VLEN    = 256,
  parameter int ELEN    = 32,
  parameter int NUM_CTX = 4,
  localparam int VL_BITS  = $clog2(VLEN) + 1,
  localparam int CTX_BITS = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CTX_BITS-1:0] req_ctx,
  input  vcfg_instruction_t   req_insn,
  input  logic [XLEN-1:0]     req_rs1,
  input  logic [XLEN-1:0]     req_rs2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [CTX_BITS-1:0] resp_ctx,
  output logic [XLEN-1:0]     resp_vl,
  output logic                resp_vill,
  input  logic [CTX_BITS-1:0] rd_ctx,
  output logic [VL_BITS-1:0]  rd_vl,
  output vtype_t              rd_vtype,
  output logic [VL_BITS-1:0]  rd_vlmax
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CTX_BITS-1:0] ctx_q, ctx_d;
  vcfg_op_e            op_q, op_d;
  vtype_t              cand_q, cand_d;
  logic [XLEN-1:0]     avl_q, avl_d;
  logic [XLEN-1:0]     resp_vl_q, resp_vl_d;
  logic                resp_vill_q, resp_vill_d;
  logic                ctx_we;

  logic [VL_BITS-1:0]  ctx_vl_q    [NUM_CTX];
  vtype_t              ctx_vtype_q [NUM_CTX];

  vcfg_op_e            dec_op;
  vtype_t              dec_vtype;
  logic [XLEN-1:0]     dec_avl;

  logic                calc_vill;
  logic [VL_BITS-1:0]  calc_vlmax;
  logic [VL_BITS-1:0]  calc_vl;
  logic                new_vill;
  logic [VL_BITS-1:0]  new_vl;
  vtype_t              new_vtype;

  logic                rd_vill_unused;
  logic [VL_BITS-1:0]  rd_vl_unused;

  // Request decode: candidate vtype and AVL source, evaluated at acceptance.
  always_comb begin
    dec_op    = vcfg_decode(req_insn);
    dec_vtype = '0;
    dec_avl   = '0;
    case (dec_op)
      OP_VSETIVLI: begin
        dec_vtype = vtype_t'(XLEN'(req_insn[29:20]));
        dec_avl   = XLEN'(req_insn[19:15]);
      end
      OP_VSETVLI, OP_VSETVL: begin
        dec_vtype = (dec_op == OP_VSETVLI) ? vtype_t'(XLEN'(req_insn[30:20]))
                                           : vtype_t'(req_rs2);
        if (req_insn[19:15] != 5'd0) begin
          dec_avl = req_rs1;
        end else if (req_insn[11:7] != 5'd0) begin
          dec_avl = '1;
        end else begin
          // Keep-vl form: the context's vl as it stands now.
          dec_avl = XLEN'(ctx_vl_q[req_ctx]);
        end
      end
      default: ;
    endcase
  end

  vcfg_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_calc (
    .vtype_i (cand_q),
    .avl_i   (avl_q),
    .vill_o  (calc_vill),
    .vlmax_o (calc_vlmax),
    .vl_o    (calc_vl)
  );

  // Final result of the CALC cycle; unrecognised encodings are illegal too.
  always_comb begin
    new_vill  = calc_vill || (op_q == OP_NONE);
    new_vl    = new_vill ? '0 : calc_vl;
    new_vtype = new_vill ? VTYPE_ILLEGAL : cand_q;
  end

  // Control FSM and request/response next-state.
  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    op_d        = op_q;
    cand_d      = cand_q;
    avl_d       = avl_q;
    resp_vl_d   = resp_vl_q;
    resp_vill_d = resp_vill_q;
    ctx_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ctx_d   = req_ctx;
          op_d    = dec_op;
          cand_d  = dec_vtype;
          avl_d   = dec_avl;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        ctx_we      = 1'b1;
        resp_vl_d   = XLEN'(new_vl);
        resp_vill_d = new_vill;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, latched request and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctx_q       <= '0;
      op_q        <= OP_NONE;
      cand_q      <= '0;
      avl_q       <= '0;
      resp_vl_q   <= '0;
      resp_vill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      op_q        <= op_d;
      cand_q      <= cand_d;
      avl_q       <= avl_d;
      resp_vl_q   <= resp_vl_d;
      resp_vill_q <= resp_vill_d;
    end
  end

  // Per-context vl/vtype file; only the latched context is ever written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_vl_q[i]    <= '0;
        ctx_vtype_q[i] <= VTYPE_ILLEGAL;
      end
    end else if (ctx_we) begin
      ctx_vl_q[ctx_q]    <= new_vl;
      ctx_vtype_q[ctx_q] <= new_vtype;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_ctx   = ctx_q;
  assign resp_vl    = resp_vl_q;
  assign resp_vill  = resp_vill_q;

  assign rd_vl    = ctx_vl_q[rd_ctx];
  assign rd_vtype = ctx_vtype_q[rd_ctx];

  vcfg_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_rd_calc (
    .vtype_i (rd_vtype),
    .avl_i   ('0),
    .vill_o  (rd_vill_unused),
    .vlmax_o (rd_vlmax),
    .vl_o    (rd_vl_unused)
  );

endmodule

// File: tb/tb_vcfg_ctx_unit.sv
// Directed bench for vcfg_ctx_unit: table of VSET* requests with
// hand-computed results, plus a response stall and a mid-operation reset.
module tb_vcfg_ctx_unit;
  import rvvLitePkg::*;

  localparam logic [31:0] VILL = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ctx;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_ctx;
  logic [31:0] resp_vl;
  logic        resp_vill;
  logic [1:0]  rd_ctx;
  logic [8:0]  rd_vl;
  logic [31:0] rd_vtype;
  logic [8:0]  rd_vlmax;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sh_vl    [4];
  logic [31:0] sh_vtype [4];

  typedef struct {
    logic [1:0]  ctx;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_vl;
    logic        exp_vill;
    logic [31:0] exp_vtype;
    logic [31:0] exp_vlmax;
  } vec_t;

  vec_t vecs[$];

  vcfg_ctx_unit #(.VLEN(256), .ELEN(32), .NUM_CTX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctx    (req_ctx),
    .req_insn   (req_insn),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_ctx   (resp_ctx),
    .resp_vl    (resp_vl),
    .resp_vill  (resp_vill),
    .rd_ctx     (rd_ctx),
    .rd_vl      (rd_vl),
    .rd_vtype   (rd_vtype),
    .rd_vlmax   (rd_vlmax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] vt);
    return {1'b0, vt, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] vt);
    return {2'b11, vt, uimm, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic vec_t mk(input logic [1:0] c, input logic [31:0] insn,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] vl, input logic vill,
                              input logic [31:0] vt, input logic [31:0] vlmax);
    vec_t v;
    v.ctx = c; v.insn = insn; v.rs1 = rs1; v.rs2 = rs2;
    v.exp_vl = vl; v.exp_vill = vill; v.exp_vtype = vt; v.exp_vlmax = vlmax;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_ctx(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_ctx = 2'(i);
      #1;
      chk($sformatf("%s ctx%0d rd_vl", tag, i), 32'(rd_vl), sh_vl[i]);
      chk($sformatf("%s ctx%0d rd_vtype", tag, i), rd_vtype, sh_vtype[i]);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int hold);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, " idle req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_ctx   = v.ctx;
    req_insn  = v.insn;
    req_rs1   = v.rs1;
    req_rs2   = v.rs2;
    rd_ctx    = v.ctx;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({t, " calc resp_valid"}, 32'(resp_valid), 32'd0);
    chk({t, " calc req_ready"}, 32'(req_ready), 32'd0);
    chk({t, " calc old rd_vl"}, 32'(rd_vl), sh_vl[v.ctx]);
    chk({t, " calc old rd_vtype"}, rd_vtype, sh_vtype[v.ctx]);
    @(posedge clk); #1;
    chk({t, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({t, " resp_vl"}, resp_vl, v.exp_vl);
    chk({t, " resp_vill"}, 32'(resp_vill), 32'(v.exp_vill));
    chk({t, " resp_ctx"}, 32'(resp_ctx), 32'(v.ctx));
    chk({t, " rd_vl"}, 32'(rd_vl), v.exp_vl);
    chk({t, " rd_vtype"}, rd_vtype, v.exp_vtype);
    chk({t, " rd_vlmax"}, 32'(rd_vlmax), v.exp_vlmax);
    sh_vl[v.ctx]    = v.exp_vl;
    sh_vtype[v.ctx] = v.exp_vtype;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("%s hold%0d resp_valid", t, h), 32'(resp_valid), 32'd1);
      chk($sformatf("%s hold%0d resp_vl", t, h), resp_vl, v.exp_vl);
      chk($sformatf("%s hold%0d resp_vill", t, h), 32'(resp_vill), 32'(v.exp_vill));
      chk($sformatf("%s hold%0d resp_ctx", t, h), 32'(resp_ctx), 32'(v.ctx));
      chk($sformatf("%s hold%0d req_ready", t, h), 32'(req_ready), 32'd0);
    end
    check_all_ctx(t);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({t, " post resp_valid"}, 32'(resp_valid), 32'd0);
    chk({t, " post req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_vl"}, resp_vl, 32'd0);
    chk({tag, " resp_vill"}, 32'(resp_vill), 32'd0);
    chk({tag, " resp_ctx"}, 32'(resp_ctx), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_ctx = 2'(i);
      #1;
      chk($sformatf("%s ctx%0d rd_vl", tag, i), 32'(rd_vl), 32'd0);
      chk($sformatf("%s ctx%0d rd_vtype", tag, i), rd_vtype, VILL);
      chk($sformatf("%s ctx%0d rd_vlmax", tag, i), 32'(rd_vlmax), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] bad_insn;
    vec_t v;

    rst_n = 1'b0; req_valid = 1'b0; req_ctx = '0; req_insn = '0;
    req_rs1 = '0; req_rs2 = '0; resp_ready = 1'b0; rd_ctx = '0;
    for (int i = 0; i < 4; i++) begin
      sh_vl[i] = 32'd0;
      sh_vtype[i] = VILL;
    end

    bad_insn = enc_vsetvli(5'd1, 5'd1, 11'h010) & ~32'h0000_7000;

    // ctx, insn, rs1, rs2, exp vl, exp vill, exp vtype, exp vlmax
    vecs.push_back(mk(2'd0, enc_vsetvli(5'd1, 5'd1, 11'h010), 32'd100, 32'd0, 32'd8, 1'b0, 32'h10, 32'd8));
    vecs.push_back(mk(2'd1, enc_vsetvli(5'd2, 5'd3, 11'h002), 32'd100, 32'd0, 32'd100, 1'b0, 32'h02, 32'd128));
    vecs.push_back(mk(2'd2, enc_vsetvl(5'd5, 5'd6, 5'd7), 32'd50, 32'h18, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd3, enc_vsetivli(5'd1, 5'd5, 10'h00F), 32'd0, 32'd0, 32'd5, 1'b0, 32'h0F, 32'd8));
    vecs.push_back(mk(2'd3, enc_vsetvli(5'd0, 5'd0, 11'h00E), 32'd0, 32'd0, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd3, enc_vsetivli(5'd1, 5'd20, 10'h000), 32'd0, 32'd0, 32'd20, 1'b0, 32'h00, 32'd32));
    vecs.push_back(mk(2'd3, enc_vsetvli(5'd0, 5'd0, 11'h00F), 32'd999, 32'd0, 32'd8, 1'b0, 32'h0F, 32'd8));
    vecs.push_back(mk(2'd3, enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd999, 32'd0, 32'd8, 1'b0, 32'h00, 32'd32));
    vecs.push_back(mk(2'd1, enc_vsetvli(5'd1, 5'd1, 11'h004), 32'd10, 32'd0, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd1, enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd10, 32'h100, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd1, enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd10, 32'h8000_0010, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd2, bad_insn, 32'd100, 32'd0, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd2, enc_vsetvli(5'd1, 5'd1, 11'h003), 32'h1000_0005, 32'd0, 32'd256, 1'b0, 32'h03, 32'd256));
    vecs.push_back(mk(2'd2, enc_vsetvli(5'd1, 5'd1, 11'h010), 32'd8, 32'd0, 32'd8, 1'b0, 32'h10, 32'd8));
    vecs.push_back(mk(2'd2, enc_vsetvli(5'd1, 5'd1, 11'h010), 32'd7, 32'd0, 32'd7, 1'b0, 32'h10, 32'd8));
    vecs.push_back(mk(2'd1, enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd3, 32'h10, 32'd3, 1'b0, 32'h10, 32'd8));
    vecs.push_back(mk(2'd0, enc_vsetvli(5'd1, 5'd1, 11'h0D0), 32'd50, 32'd0, 32'd8, 1'b0, 32'hD0, 32'd8));
    vecs.push_back(mk(2'd0, enc_vsetivli(5'd1, 5'd0, 10'h010), 32'd0, 32'd0, 32'd0, 1'b0, 32'h10, 32'd8));
    vecs.push_back(mk(2'd1, enc_vsetvli(5'd1, 5'd1, 11'h00D), 32'd100, 32'd0, 32'd0, 1'b1, VILL, 32'd0));
    vecs.push_back(mk(2'd1, enc_vsetvli(5'd1, 5'd1, 11'h006), 32'd100, 32'd0, 32'd8, 1'b0, 32'h06, 32'd8));
    vecs.push_back(mk(2'd0, enc_vsetvli(5'd1, 5'd1, 11'h013), 32'd1000, 32'd0, 32'd64, 1'b0, 32'h13, 32'd64));

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i], 0);
    end

    // rs1=x0, rd!=x0 requests VLMAX; the response is stalled for 5 cycles.
    v = mk(2'd0, enc_vsetvli(5'd1, 5'd0, 11'h003), 32'd7, 32'd0, 32'd256, 1'b0, 32'h03, 32'd256);
    run_vec(100, v, 5);

    // Reset while a request sits in CALC: nothing is written.
    @(negedge clk);
    req_valid = 1'b1;
    req_ctx   = 2'd1;
    req_insn  = enc_vsetvli(5'd1, 5'd1, 11'h002);
    req_rs1   = 32'd100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstcalc in calc", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rstcalc");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sh_vl[i] = 32'd0;
      sh_vtype[i] = VILL;
    end
    v = mk(2'd2, enc_vsetvli(5'd1, 5'd1, 11'h010), 32'd100, 32'd0, 32'd8, 1'b0, 32'h10, 32'd8);
    run_vec(200, v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
